wb_stage_regfile: RTL and testbench

//  Write-back stage of the 5-stage MIPS pipeline: consumes the MEM/WB pipeline

---
 rtl/wb_stage_regfile_pkg.sv | 21 ++
 rtl/wb_stage_regfile_if.sv | 41 ++++
 rtl/wb_stage_regfile_regfile_2r1w.sv | 61 ++++++
 rtl/wb_stage_regfile.sv | 84 ++++++++
 tb/tb_wb_stage_regfile.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_stage_regfile_pkg.sv
// rtl/wb_stage_regfile_pkg.sv - shared pipeline definitions for the write-back stage
// Purpose: write-back source encodings, bubble/zero-register constants and the
//          link-address helper used by the WB stage and its register file.
// Ports:   none (package)
package wb_stage_regfile_pkg;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_MEM  = 2'b01,
    WB_SEL_LINK = 2'b10
  } wb_sel_e;

  localparam logic [31:0] NOP_INST = 32'h0;
  localparam logic [4:0]  REG_ZERO = 5'd0;

  // Return address written by jal/jalr: the instruction after the jump.
  function automatic logic [31:0] link_addr(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/wb_stage_regfile_if.sv
// rtl/wb_stage_regfile_if.sv - MEM/WB, ID read-port and retire-trace bundle
// Purpose: groups the MEM/WB pipeline register outputs, the two ID read ports
//          and the retire trace of the write-back stage.
// Ports:   master = pipeline side (drives MEM/WB fields and read addresses),
//          slave  = write-back stage (drives read data, wb_data, retire trace).
interface wb_stage_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
);
  logic              MEM_WB_RegWrite;
  logic [1:0]        MEM_WB_DatatoReg;
  logic [DATA_W-1:0] MEM_WB_Data_in;
  logic [DATA_W-1:0] MEM_WB_result;
  logic [ADDR_W-1:0] MEM_WB_rd;
  logic [31:0]       MEM_WB_inst;
  logic [31:0]       MEM_WB_PC;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] wb_data;
  logic              retire_valid;
  logic [31:0]       retire_pc;
  logic [31:0]       retire_inst;
  logic [CNT_W-1:0]  retire_count;

  modport master (
    output MEM_WB_RegWrite, MEM_WB_DatatoReg, MEM_WB_Data_in, MEM_WB_result,
           MEM_WB_rd, MEM_WB_inst, MEM_WB_PC, rs_addr, rt_addr,
    input  rs_data, rt_data, wb_data, retire_valid, retire_pc, retire_inst,
           retire_count
  );

  modport slave (
    input  MEM_WB_RegWrite, MEM_WB_DatatoReg, MEM_WB_Data_in, MEM_WB_result,
           MEM_WB_rd, MEM_WB_inst, MEM_WB_PC, rs_addr, rt_addr,
    output rs_data, rt_data, wb_data, retire_valid, retire_pc, retire_inst,
           retire_count
  );
endinterface

// File: rtl/wb_stage_regfile_regfile_2r1w.sv
// rtl/wb_stage_regfile_regfile_2r1w.sv - 2-read 1-write general register file
// Purpose: 2**ADDR_W x DATA_W register array with synchronous reset, register 0
//          hardwired to zero and same-cycle write-to-read bypass on both ports.
// Ports:   clk, rst (sync, active-high); we_i/waddr_i/wdata_i write port;
//          raddr_a_i/raddr_b_i read addresses; rdata_a_o/rdata_b_o read data.
module regfile_2r1w
  import wb_stage_regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);
  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_q [NREG];
  logic              wr_en;

  // Writes to register 0 are dropped so the array copy never leaves zero.
  assign wr_en = we_i && (waddr_i != ZERO_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Write-before-read: a reader in the commit cycle sees the incoming value.
  // The bypass uses we_i rather than wr_en; the zero test comes first anyway.
  always_comb begin
    rdata_a_o = regs_q[raddr_a_i];
    if (raddr_a_i == ZERO_IDX) begin
      rdata_a_o = '0;
    end else if (we_i && (waddr_i == raddr_a_i)) begin
      rdata_a_o = wdata_i;
    end
  end

  always_comb begin
    rdata_b_o = regs_q[raddr_b_i];
    if (raddr_b_i == ZERO_IDX) begin
      rdata_b_o = '0;
    end else if (we_i && (waddr_i == raddr_b_i)) begin
      rdata_b_o = wdata_i;
    end
  end

endmodule

// File: rtl/wb_stage_regfile.sv
// rtl/wb_stage_regfile.sv - MIPS write-back stage with register file and retire trace
// Purpose: selects the write-back value from the MEM/WB fields, commits it to
//          the register file (which serves the ID read ports with bypass) and
//          keeps a registered retire trace and retired-instruction counter.
// Ports:   clk, rst (sync, active-high); wb = slave side of wb_stage_regfile_if.
module wb_stage_regfile
  import wb_stage_regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input logic             clk,
  input logic             rst,
  wb_stage_regfile_if.slave wb
);
  logic [DATA_W-1:0] wb_data;
  logic              retire_valid_q, retire_valid_d;
  logic [31:0]       retire_pc_q, retire_pc_d;
  logic [31:0]       retire_inst_q, retire_inst_d;
  logic [CNT_W-1:0]  retire_count_q, retire_count_d;
  logic              retiring;

  // 2'b11 is unused by the decoder and falls back to the ALU result.
  always_comb begin
    wb_data = wb.MEM_WB_result;
    case (wb.MEM_WB_DatatoReg)
      WB_SEL_MEM:  wb_data = wb.MEM_WB_Data_in;
      WB_SEL_LINK: wb_data = DATA_W'(link_addr(wb.MEM_WB_PC));
      default:     wb_data = wb.MEM_WB_result;
    endcase
  end

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we_i      (wb.MEM_WB_RegWrite),
    .waddr_i   (wb.MEM_WB_rd),
    .wdata_i   (wb_data),
    .raddr_a_i (wb.rs_addr),
    .raddr_b_i (wb.rt_addr),
    .rdata_a_o (wb.rs_data),
    .rdata_b_o (wb.rt_data)
  );

  // Any non-bubble instruction retires, whether or not it writes a register.
  assign retiring = (wb.MEM_WB_inst != NOP_INST);

  always_comb begin
    retire_valid_d = retiring;
    retire_pc_d    = retire_pc_q;
    retire_inst_d  = retire_inst_q;
    retire_count_d = retire_count_q;
    if (retiring) begin
      retire_pc_d    = wb.MEM_WB_PC;
      retire_inst_d  = wb.MEM_WB_inst;
      retire_count_d = retire_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retire_valid_q <= 1'b0;
      retire_pc_q    <= '0;
      retire_inst_q  <= '0;
      retire_count_q <= '0;
    end else begin
      retire_valid_q <= retire_valid_d;
      retire_pc_q    <= retire_pc_d;
      retire_inst_q  <= retire_inst_d;
      retire_count_q <= retire_count_d;
    end
  end

  assign wb.wb_data      = wb_data;
  assign wb.retire_valid = retire_valid_q;
  assign wb.retire_pc    = retire_pc_q;
  assign wb.retire_inst  = retire_inst_q;
  assign wb.retire_count = retire_count_q;

endmodule

// File: tb/tb_wb_stage_regfile.sv
// tb/tb_wb_stage_regfile.sv - directed self-checking bench for wb_stage_regfile
module tb_wb_stage_regfile;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  wb_stage_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) bus ();
  wb_stage_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  bus4 ();

  wb_stage_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  wb_stage_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .wb  (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.MEM_WB_RegWrite  = 1'b0;
    bus.MEM_WB_DatatoReg = 2'b00;
    bus.MEM_WB_Data_in   = 32'h0;
    bus.MEM_WB_result    = 32'h0;
    bus.MEM_WB_rd        = 5'd0;
    bus.MEM_WB_inst      = 32'h0;
    bus.MEM_WB_PC        = 32'h0;
    bus.rs_addr          = 5'd0;
    bus.rt_addr          = 5'd0;
  endtask

  task automatic test_reset();
    logic [31:0] val17;
    val17 = 32'h0;
    for (int i = 1; i < 32; i++) begin
      bus.MEM_WB_RegWrite = 1'b1;
      bus.MEM_WB_rd       = 5'(i);
      bus.MEM_WB_result   = $urandom | 32'h1;
      bus.MEM_WB_inst     = 32'h1;
      bus.MEM_WB_PC       = 32'(i * 4);
      if (i == 17) val17 = bus.MEM_WB_result;
      tick();
    end
    idle_inputs();
    bus.rs_addr = 5'd17;
    #1;
    checks++;
    if (bus.rs_data !== val17) begin
      failures++; $display("FAIL pre_reset_r17: got %h expected %h", bus.rs_data, val17);
    end
    checks++;
    if (bus.retire_count !== 32'd31) begin
      failures++; $display("FAIL pre_reset_count: got %0d expected 31", bus.retire_count);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.retire_count !== 32'd0 || bus.retire_valid !== 1'b0 || bus.retire_pc !== 32'h0) begin
      failures++;
      $display("FAIL reset_retire: got cnt=%0d v=%b pc=%h expected 0/0/0",
               bus.retire_count, bus.retire_valid, bus.retire_pc);
    end
    for (int r = 0; r < 32; r++) begin
      bus.rs_addr = 5'(r);
      bus.rt_addr = 5'(31 - r);
      #1;
      checks++;
      if (bus.rs_data !== 32'h0 || bus.rt_data !== 32'h0) begin
        failures++;
        $display("FAIL reset_reg%0d: got rs=%h rt=%h expected 0", r, bus.rs_data, bus.rt_data);
      end
    end
  endtask

  task automatic test_bypass();
    idle_inputs();
    bus.MEM_WB_RegWrite = 1'b1;
    bus.MEM_WB_rd       = 5'd5;
    bus.MEM_WB_result   = 32'hDEADBEEF;
    bus.rs_addr         = 5'd5;
    bus.rt_addr         = 5'd5;
    #1;
    checks++;
    if (bus.rs_data !== 32'hDEADBEEF || bus.rt_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL bypass_same_cycle: got rs=%h rt=%h expected deadbeef", bus.rs_data, bus.rt_data);
    end
    tick();
    bus.MEM_WB_RegWrite = 1'b0;
    bus.MEM_WB_result   = 32'h0;
    #1;
    checks++;
    if (bus.rs_data !== 32'hDEADBEEF) begin
      failures++; $display("FAIL bypass_next_cycle: got %h expected deadbeef", bus.rs_data);
    end
  endtask

  task automatic test_zero_reg();
    idle_inputs();
    bus.MEM_WB_RegWrite = 1'b1;
    bus.MEM_WB_rd       = 5'd0;
    bus.MEM_WB_result   = 32'h1234;
    bus.rs_addr         = 5'd0;
    #1;
    checks++;
    if (bus.rs_data !== 32'h0 || bus.wb_data !== 32'h1234) begin
      failures++;
      $display("FAIL zero_same_cycle: got rs=%h wb=%h expected 0/1234", bus.rs_data, bus.wb_data);
    end
    tick();
    bus.MEM_WB_RegWrite = 1'b0;
    #1;
    checks++;
    if (bus.rs_data !== 32'h0) begin
      failures++; $display("FAIL zero_next_cycle: got %h expected 0", bus.rs_data);
    end
  endtask

  task automatic test_wb_mux();
    idle_inputs();
    bus.MEM_WB_RegWrite  = 1'b1;
    bus.MEM_WB_DatatoReg = 2'b01;
    bus.MEM_WB_Data_in   = 32'hA5A5A5A5;
    bus.MEM_WB_result    = 32'h11111111;
    bus.MEM_WB_rd        = 5'd8;
    #1;
    checks++;
    if (bus.wb_data !== 32'hA5A5A5A5) begin
      failures++; $display("FAIL mux_mem: got %h expected a5a5a5a5", bus.wb_data);
    end
    tick();
    bus.MEM_WB_DatatoReg = 2'b10;
    bus.MEM_WB_PC        = 32'h00400010;
    bus.MEM_WB_rd        = 5'd31;
    #1;
    checks++;
    if (bus.wb_data !== 32'h00400014) begin
      failures++; $display("FAIL mux_link: got %h expected 00400014", bus.wb_data);
    end
    tick();
    bus.MEM_WB_RegWrite  = 1'b0;
    bus.MEM_WB_DatatoReg = 2'b11;
    bus.MEM_WB_result    = 32'h0BADF00D;
    bus.rs_addr          = 5'd8;
    bus.rt_addr          = 5'd31;
    #1;
    checks++;
    if (bus.wb_data !== 32'h0BADF00D) begin
      failures++; $display("FAIL mux_sel11: got %h expected 0badf00d", bus.wb_data);
    end
    checks++;
    if (bus.rs_data !== 32'hA5A5A5A5 || bus.rt_data !== 32'h00400014) begin
      failures++;
      $display("FAIL mux_commit: got r8=%h r31=%h expected a5a5a5a5/00400014", bus.rs_data, bus.rt_data);
    end
  endtask

  task automatic test_retire();
    logic [31:0] insts [4];
    logic [31:0] exp_cnt [4];
    logic [31:0] exp_pc [4];
    logic [31:0] exp_inst [4];
    logic        exp_v [4];
    insts    = '{32'h1, 32'h0, 32'h0, 32'h3};
    exp_cnt  = '{32'd1, 32'd1, 32'd1, 32'd2};
    exp_pc   = '{32'h0, 32'h0, 32'h0, 32'hC};
    exp_inst = '{32'h1, 32'h1, 32'h1, 32'h3};
    exp_v    = '{1'b1, 1'b0, 1'b0, 1'b1};
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      bus.MEM_WB_inst = insts[k];
      bus.MEM_WB_PC   = 32'(k * 4);
      tick();
      checks++;
      if (bus.retire_count !== exp_cnt[k] || bus.retire_pc !== exp_pc[k] ||
          bus.retire_valid !== exp_v[k] || bus.retire_inst !== exp_inst[k]) begin
        failures++;
        $display("FAIL retire_step%0d: got cnt=%0d pc=%h v=%b inst=%h expected cnt=%0d pc=%h v=%b inst=%h",
                 k, bus.retire_count, bus.retire_pc, bus.retire_valid, bus.retire_inst,
                 exp_cnt[k], exp_pc[k], exp_v[k], exp_inst[k]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    idle_inputs();
    bus.MEM_WB_RegWrite = 1'b1;
    bus.MEM_WB_rd       = 5'd3;
    bus.MEM_WB_result   = 32'h77;
    bus.MEM_WB_inst     = 32'h5;
    bus.MEM_WB_PC       = 32'h100;
    bus.rs_addr         = 5'd3;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.rs_data !== 32'h77) begin
      failures++; $display("FAIL reset_bypass: got %h expected 77", bus.rs_data);
    end
    tick();
    rst = 1'b0;
    idle_inputs();
    bus.rs_addr = 5'd3;
    #1;
    checks++;
    if (bus.rs_data !== 32'h0 || bus.retire_count !== 32'd0 || bus.retire_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_midstream: got r3=%h cnt=%0d v=%b expected 0/0/0",
               bus.rs_data, bus.retire_count, bus.retire_valid);
    end
  endtask

  task automatic test_count_wrap();
    for (int k = 0; k < 15; k++) begin
      bus4.MEM_WB_inst = 32'h1;
      bus4.MEM_WB_PC   = 32'(k * 4);
      tick();
    end
    checks++;
    if (bus4.retire_count !== 4'hF) begin
      failures++; $display("FAIL wrap_preload: got %0d expected 15", bus4.retire_count);
    end
    bus4.MEM_WB_inst = 32'h2;
    bus4.MEM_WB_PC   = 32'h40;
    tick();
    checks++;
    if (bus4.retire_count !== 4'h0 || bus4.retire_valid !== 1'b1 || bus4.retire_pc !== 32'h40) begin
      failures++;
      $display("FAIL wrap_rollover: got cnt=%0d v=%b pc=%h expected 0/1/00000040",
               bus4.retire_count, bus4.retire_valid, bus4.retire_pc);
    end
    bus4.MEM_WB_inst = 32'h0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle_inputs();
    bus4.MEM_WB_RegWrite  = 1'b0;
    bus4.MEM_WB_DatatoReg = 2'b00;
    bus4.MEM_WB_Data_in   = 32'h0;
    bus4.MEM_WB_result    = 32'h0;
    bus4.MEM_WB_rd        = 5'd0;
    bus4.MEM_WB_inst      = 32'h0;
    bus4.MEM_WB_PC        = 32'h0;
    bus4.rs_addr          = 5'd0;
    bus4.rt_addr          = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_bypass();
    test_zero_reg();
    test_wb_mux();
    test_retire();
    test_reset_midstream();
    test_count_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
